// File: rtl/alu_issue_if.sv
// Instruction, ALU and result signals of alu_issue, bundled as one bus.
// The slave modport is the issue controller; master is the upstream/ALU side.
interface alu_issue_if #(
  parameter int unsigned WIDTH = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic             instr_ld;
  logic [1:0]       instr_op;
  logic [1:0]       instr_rd;
  logic [1:0]       instr_rs1;
  logic [1:0]       instr_rs2;
  logic [WIDTH-1:0] instr_imm;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_i0;
  logic [WIDTH-1:0] alu_i1;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             carry_flag;

  modport master (
    output instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output alu_o, alu_cout,
    input  instr_ready, alu_op, alu_i0, alu_i1,
    input  res_valid, res_data, res_carry, carry_flag
  );

  modport slave (
    input  instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  alu_o, alu_cout,
    output instr_ready, alu_op, alu_i0, alu_i1,
    output res_valid, res_data, res_carry, carry_flag
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback controller for the 16-bit alu: reads operands from a 4-entry
// register file at accept, writes the ALU result (or immediate) back one cycle later.
module alu_issue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 4
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);
  localparam logic IDLE = 1'b0;
  localparam logic EXEC = 1'b1;

  logic             state;
  logic [WIDTH-1:0] regs [NREG];
  logic [1:0]       rd_q;
  logic             ld_q;
  logic [WIDTH-1:0] imm_q;
  logic             accept;

  always_comb begin
    bus.instr_ready = (state == IDLE) && reset;
    accept          = bus.instr_valid && bus.instr_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      regs           <= '{default: '0};
      rd_q           <= '0;
      ld_q           <= 1'b0;
      imm_q          <= '0;
      bus.alu_op     <= '0;
      bus.alu_i0     <= '0;
      bus.alu_i1     <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_carry  <= 1'b0;
      bus.carry_flag <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          rd_q       <= bus.instr_rd;
          ld_q       <= bus.instr_ld;
          imm_q      <= bus.instr_imm;
          bus.alu_op <= bus.instr_op;
          bus.alu_i0 <= regs[bus.instr_rs1];
          bus.alu_i1 <= regs[bus.instr_rs2];
          state      <= EXEC;
        end
      end else begin
        // Loads still drove the ALU at accept; its result is simply discarded here.
        if (ld_q) begin
          regs[rd_q]    <= imm_q;
          bus.res_data  <= imm_q;
          bus.res_carry <= 1'b0;
        end else begin
          regs[rd_q]     <= bus.alu_o;
          bus.res_data   <= bus.alu_o;
          bus.res_carry  <= bus.alu_cout;
          bus.carry_flag <= bus.alu_cout;
        end
        bus.res_valid <= 1'b1;
        state         <= IDLE;
      end
    end
  end
endmodule
